// File: rtl/md_sequencer.sv
// md_sequencer: multiply/divide unit beside the E-stage ALU.
//   Accepts mult/multu/div/divu/mthi/mtlo from E and owns the HI/LO registers.
//   Products and quotients are computed in the accept cycle and then held in
//   staging registers. They are committed to HI/LO after a fixed busy window,
//   so the pipeline sees the latency of a real multi-cycle unit.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   e_valid, e_md_op    E-stage instruction valid / md opcode (0 none,1 mult,
//                       2 multu,3 div,4 divu,5 mthi,6 mtlo,7 none)
//   e_rs, e_rt          forwarded operands
//   d_uses_md           D-stage instruction touches the md unit
//   start               md op accepted this cycle (comb)
//   busy                operation in progress (from state register)
//   stall_md            D-stage stall request (comb)
//   hi, lo              architectural HI/LO
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        e_valid,
  input  logic [2:0]  e_md_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_uses_md,
  output logic        start,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_LAST = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LAST  = 4'(DIV_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] res_hi_q, res_lo_q, hi_q, lo_q;
  logic        dz_q;  // staged result must be dropped (divide by zero)

  logic        is_md, is_mul, signed_op, neg_a, neg_b, div_zero;
  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, b_safe, uq, ur, quo, rem;

  always_comb begin
    is_md     = (e_md_op >= OP_MULT) && (e_md_op <= OP_DIVU);
    is_mul    = (e_md_op == OP_MULT) || (e_md_op == OP_MULTU);
    signed_op = (e_md_op == OP_MULT) || (e_md_op == OP_DIV);
    // The low 64 bits of a 64x64 product of sign-extended operands are the
    // signed 32x32 product, so one multiplier covers both flavours.
    prod      = {{32{signed_op & e_rs[31]}}, e_rs} * {{32{signed_op & e_rt[31]}}, e_rt};
    // Signed divide on magnitudes: this gives truncation toward zero and a
    // remainder with the dividend's sign. 0x80000000 / -1 wraps to 0x80000000.
    neg_a     = signed_op & e_rs[31];
    neg_b     = signed_op & e_rt[31];
    a_mag     = neg_a ? -e_rs : e_rs;
    b_mag     = neg_b ? -e_rt : e_rt;
    div_zero  = (e_rt == 32'd0);
    b_safe    = div_zero ? 32'd1 : b_mag;  // keep the divider defined; result is discarded
    uq        = a_mag / b_safe;
    ur        = a_mag % b_safe;
    quo       = (neg_a ^ neg_b) ? -uq : uq;
    rem       = neg_a ? -ur : ur;
  end

  assign start    = e_valid && is_md && (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign stall_md = d_uses_md && (start || busy);
  assign hi       = hi_q;
  assign lo       = lo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (is_mul) begin
              res_hi_q <= prod[63:32];
              res_lo_q <= prod[31:0];
              dz_q     <= 1'b0;
              cnt_q    <= MULT_LAST;
              state_q  <= MUL;
            end else begin
              res_hi_q <= rem;
              res_lo_q <= quo;
              dz_q     <= div_zero;
              cnt_q    <= DIV_LAST;
              state_q  <= DIV;
            end
          end else if (e_valid && e_md_op == OP_MTHI) begin
            hi_q <= e_rs;
          end else if (e_valid && e_md_op == OP_MTLO) begin
            lo_q <= e_rs;
          end
        end
        MUL, DIV: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            if (!dz_q) begin
              hi_q <= res_hi_q;
              lo_q <= res_lo_q;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
